// File: rtl/reg_file_nport.sv
// DEPTH x WIDTH register file: two combinational read ports, byte-masked write, zero entry 0, bulk-clear sweep.
// Optional same-cycle write-to-read forwarding is enabled with `define REG_FILE_BYPASS_EN.
module reg_file_nport #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int NB = WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [NB-1:0]     wbe,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b,
    input  logic              clr_req,
    output logic              busy
);

    // state | meaning
    // IDLE  | normal operation, writes and clear requests accepted
    // CLEAR | sweeping entries 0..DEPTH-1 to zero, one per falling edge
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              wa_ok, ra_ok, rb_ok;

    function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old,
                                                     input logic [WIDTH-1:0] nw,
                                                     input logic [NB-1:0]    be);
        logic [WIDTH-1:0] r;
        r = old;
        for (int k = 0; k < NB; k++)
            if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    // Range checks only exist when DEPTH leaves unused address codes.
    if (DEPTH == (1 << ADDR_W)) begin : g_pow2
        assign wa_ok = 1'b1;
        assign ra_ok = 1'b1;
        assign rb_ok = 1'b1;
    end else begin : g_npow2
        assign wa_ok = int'(waddr)   < DEPTH;
        assign ra_ok = int'(raddr_a) < DEPTH;
        assign rb_ok = int'(raddr_b) < DEPTH;
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            state   <= IDLE;
            clr_ptr <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs && clr_req) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                        busy    <= 1'b1;
                    end else if (cs && we && wa_ok && waddr != '0) begin
                        mem[waddr] <= merge_bytes(mem[waddr], wdata, wbe);
                    end
                end
                CLEAR: begin
                    mem[clr_ptr] <= '0;
                    if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rdata_a = (ra_ok && raddr_a != '0) ? mem[raddr_a] : '0;
        rdata_b = (rb_ok && raddr_b != '0) ? mem[raddr_b] : '0;
`ifdef REG_FILE_BYPASS_EN
        // Forward the write that will commit on the coming falling edge.
        if (cs && we && !busy && raddr_a == waddr && raddr_a != '0)
            rdata_a = merge_bytes(rdata_a, wdata, wbe);
        if (cs && we && !busy && raddr_b == waddr && raddr_b != '0)
            rdata_b = merge_bytes(rdata_b, wdata, wbe);
`endif
    end

endmodule

// File: tb/tb_reg_file_nport.sv
// Randomized scoreboard bench for reg_file_nport with an array-based reference model.
module tb_reg_file_nport;
    localparam int DEPTH = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs = 1'b0, we = 1'b0, clr_req = 1'b0;
    logic [AW-1:0] waddr = '0, raddr_a = '0, raddr_b = '0;
    logic [31:0]   wdata = '0;
    logic [3:0]    wbe = '0;
    logic [31:0]   rdata_a, rdata_b;
    logic          busy;

    reg_file_nport #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .waddr(waddr), .wdata(wdata),
        .wbe(wbe), .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a),
        .rdata_b(rdata_b), .clr_req(clr_req), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        ebusy;
    } exp_t;

    exp_t        sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] ref_mem [DEPTH];
    bit          busy_m;
    int          edges_left;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        busy_m = 1'b0;
        edges_left = 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [AW-1:0] ra);
        logic [31:0] r;
        r = (ra == 0) ? 32'h0 : ref_mem[ra];
`ifdef REG_FILE_BYPASS_EN
        if (cs && we && !busy_m && ra == waddr && ra != 0)
            for (int k = 0; k < 4; k++) if (wbe[k]) r[8*k +: 8] = wdata[8*k +: 8];
`endif
        return r;
    endfunction

    // Effect of one falling edge on the model, given the driven inputs.
    function automatic void model_edge();
        if (busy_m) begin
            ref_mem[DEPTH - edges_left] = '0;
            edges_left--;
            if (edges_left == 0) busy_m = 1'b0;
        end else if (cs && clr_req) begin
            busy_m = 1'b1;
            edges_left = DEPTH;
        end else if (cs && we && waddr != 0) begin
            for (int k = 0; k < 4; k++)
                if (wbe[k]) ref_mem[waddr][8*k +: 8] = wdata[8*k +: 8];
        end
    endfunction

    task automatic step(input bit c, input bit w, input bit cl, input logic [AW-1:0] wa,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [AW-1:0] ra, input logic [AW-1:0] rb, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        cs = c; we = w; clr_req = cl; waddr = wa; wdata = wd; wbe = be;
        raddr_a = ra; raddr_b = rb;
        e.name = nm;
        e.ea = model_read(ra);
        e.eb = model_read(rb);
        e.ebusy = busy_m;
        sbq.push_back(e);
        model_edge();
    endtask

    always @(posedge clk) begin
        #3;
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            check({e.name, "_a"}, rdata_a, e.ea);
            check({e.name, "_b"}, rdata_b, e.eb);
            check({e.name, "_busy"}, {31'b0, busy}, {31'b0, e.ebusy});
        end
    end

    initial begin
        logic [31:0] byp_exp;
        model_reset();
        #2 rst = 1'b0;
        #2;
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_rd_a", rdata_a, 32'h0);
        #13 rst = 1'b1;

        for (int i = 0; i < 16; i++)
            step(0, 0, 0, 0, 0, 0, AW'(i), AW'(i + 16), "reset_read");

        step(1, 1, 0, 5, 32'hFFFFFFFF, 4'hF, 5, 0, "bm_w1");
        step(1, 1, 0, 5, 32'h12345678, 4'b0101, 5, 0, "bm_w2");
        step(0, 0, 0, 0, 0, 0, 5, 5, "bm_rd");
        #2 check("bm_const", rdata_a, 32'hFF34FF78);

        step(1, 1, 0, 0, 32'hDEADBEEF, 4'hF, 0, 31, "e0_w");
        step(1, 1, 0, 31, 32'hCAFEF00D, 4'hF, 0, 31, "e31_w");
        step(0, 0, 0, 0, 0, 0, 0, 31, "dual_rd");
        #2 check("e0_const", rdata_a, 32'h0);
        check("e31_const", rdata_b, 32'hCAFEF00D);

        repeat (300)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1), 0, AW'($urandom),
                 $urandom, 4'($urandom), AW'($urandom), AW'($urandom), "rand");

        for (int i = 1; i < DEPTH; i++)
            step(1, 1, 0, AW'(i), $urandom | 32'h1, 4'hF, AW'(i), 0, "fill");
        step(1, 1, 1, 7, 32'h0BADCAFE, 4'hF, 7, 20, "clr_start");
        for (int n = 0; n < DEPTH; n++)
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 AW'($urandom), $urandom, 4'hF, 20, AW'($urandom_range(1, 10)), "sweep");
        for (int i = 0; i < 16; i++)
            step(0, 0, 0, 0, 0, 0, AW'(i), AW'(i + 16), "post_clr");
        step(1, 1, 0, 12, 32'h5A5A0001, 4'hF, 12, 0, "post_clr_w");
        step(0, 0, 0, 0, 0, 0, 12, 0, "post_clr_rd");

        for (int i = 1; i < DEPTH; i++)
            step(1, 1, 0, AW'(i), $urandom | 32'h1, 4'hF, AW'(i), 0, "fill2");
        step(1, 0, 1, 0, 0, 0, 20, 0, "clr2_start");
        repeat (10) step(0, 0, 0, 0, 0, 0, 20, 5, "sweep2");
        @(posedge clk);
        #2;
        cs = 0; we = 0; clr_req = 0;
        rst = 1'b0;
        model_reset();
        #1 check("midrst_busy", {31'b0, busy}, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            raddr_a = AW'(i);
            raddr_b = AW'(DEPTH - 1 - i);
            #1;
            check("midrst_a", rdata_a, 32'h0);
            check("midrst_b", rdata_b, 32'h0);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        step(1, 1, 0, 9, 32'h600DF00D, 4'hF, 9, 0, "rel_w");
        step(0, 0, 0, 0, 0, 0, 9, 0, "rel_rd");
        #2 check("rel_const", rdata_a, 32'h600DF00D);

        step(1, 1, 0, 3, 32'h11111111, 4'hF, 3, 0, "byp_init");
        step(1, 1, 0, 3, 32'hAABBCCDD, 4'b0011, 3, 3, "byp_pre");
`ifdef REG_FILE_BYPASS_EN
        byp_exp = 32'h1111CCDD;
`else
        byp_exp = 32'h11111111;
`endif
        #2 check("byp_pre_const", rdata_a, byp_exp);
        step(0, 0, 0, 0, 0, 0, 3, 3, "byp_post");
        #2 check("byp_post_const", rdata_a, 32'h1111CCDD);

        @(posedge clk);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
